// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and sizing helpers for the two-port on-chip memory arbiter.
package onchip_mem_arb_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with bounded lock; grant is combinational,
// tie-break and hold state are registered.
module rr_arbiter2
  import onchip_mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] grant,
  output port_t      last_grant
);

  localparam int HOLD_W = hold_w(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;
  port_t             winner;
  port_t             other_last;
  port_t             other_win;
  logic              keep;

  always_comb begin
    other_last = port_t'(~last_grant);
    keep       = lock[last_grant] && (hold_cnt < HOLD_W'(MAX_HOLD));
    winner     = last_grant;
    grant      = 2'b00;
    if (en && (req != 2'b00)) begin
      if (req == 2'b11) winner = keep ? last_grant : other_last;
      else              winner = req[1] ? PORT1 : PORT0;
      grant[winner] = 1'b1;
    end
    other_win = port_t'(~winner);
  end

  // Counter holds the length of the current run while the other port waits;
  // a switch starts a new run at 1 so MAX_HOLD bounds the run exactly.
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if (grant != 2'b00) begin
      if (!req[other_win])                     hold_cnt_nxt = '0;
      else if (winner != last_grant)           hold_cnt_nxt = HOLD_W'(1);
      else if (hold_cnt != HOLD_W'(MAX_HOLD))  hold_cnt_nxt = hold_cnt + HOLD_W'(1);
    end else if (!req[other_last]) begin
      hold_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PORT1;
      hold_cnt   <= '0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
      if (grant != 2'b00) last_grant <= winner;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a 1-cycle-latency single-port memory between two Avalon-MM masters;
// accepted commands drive the memory the same cycle, read data returns at T+1.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_proto
);

  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] grant;
  port_t      last_grant;
  port_t      sel;
  port_t      rd_port;
  logic       rd_pending;
  logic       run;

  assign req  = {m1_read | m1_write, m0_read | m0_write};
  assign lock = {m1_lock, m0_lock};

  rr_arbiter2 #(
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (run),
    .req        (req),
    .lock       (lock),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // With no grant the bus keeps steering from the previous winner.
  always_comb begin
    sel = last_grant;
    if (grant[1])      sel = PORT1;
    else if (grant[0]) sel = PORT0;
  end

  assign mem_address    = (sel == PORT1) ? m1_address    : m0_address;
  assign mem_byteenable = (sel == PORT1) ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = (sel == PORT1) ? m1_writedata  : m0_writedata;
  assign mem_chipselect = |grant;
  assign mem_write      = grant[1] ? m1_write : (grant[0] & m0_write);
  assign mem_clken      = run;

  assign m0_waitrequest   = ~grant[0];
  assign m1_waitrequest   = ~grant[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pending & (rd_port == PORT0);
  assign m1_readdatavalid = rd_pending & (rd_port == PORT1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run        <= 1'b0;
      rd_pending <= 1'b0;
      rd_port    <= PORT0;
      err_proto  <= 1'b0;
    end else begin
      run        <= 1'b1;
      rd_pending <= mem_chipselect & ~mem_write;
      if (mem_chipselect) rd_port <= sel;
      err_proto  <= err_proto | (m0_read & m0_write) | (m1_read & m1_write);
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench: a memory model behind the arbiter, a shadow copy for
// expected read data, and a log of which port each accepted transfer came from.
module tb_onchip_mem_arbiter;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int MH = 4;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          lk;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [DW-1:0] d;
  } cmd_t;

  typedef struct packed {
    logic          p;
    logic [DW-1:0] d;
    logic [31:0]   due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    rd, wr, lk;
  logic [AW-1:0] ad [2];
  logic [3:0]    be [2];
  logic [DW-1:0] wd [2];
  logic [1:0]    wreq, rdv;
  logic [DW-1:0] rdat [2];
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic          mem_chipselect, mem_write, mem_clken, err_proto;
  logic [DW-1:0] mem_q;

  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] cyc   = 0;
  cmd_t        cq0[$];
  cmd_t        cq1[$];
  exp_t        eq[$];
  int          glog[$];

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (ad[0]),
    .m0_byteenable    (be[0]),
    .m0_read          (rd[0]),
    .m0_write         (wr[0]),
    .m0_writedata     (wd[0]),
    .m0_lock          (lk[0]),
    .m0_waitrequest   (wreq[0]),
    .m0_readdata      (rdat[0]),
    .m0_readdatavalid (rdv[0]),
    .m1_address       (ad[1]),
    .m1_byteenable    (be[1]),
    .m1_read          (rd[1]),
    .m1_write         (wr[1]),
    .m1_writedata     (wd[1]),
    .m1_lock          (lk[1]),
    .m1_waitrequest   (wreq[1]),
    .m1_readdata      (rdat[1]),
    .m1_readdatavalid (rdv[1]),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_q),
    .err_proto        (err_proto)
  );

  function automatic logic [31:0] init_val(input int i);
    logic [31:0] x;
    x = 32'(i);
    if (i == 16) return 32'hDEADBEEF;
    return (x * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] <= init_val(i);
  end

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_q <= ram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic r, input logic w, input logic l,
                              input logic [AW-1:0] a, input logic [3:0] b, input logic [DW-1:0] d);
    cmd_t c;
    c.rd = r; c.wr = w; c.lk = l; c.a = a; c.be = b; c.d = d;
    return c;
  endfunction

  task automatic present();
    cmd_t c0, c1;
    c0 = '0;
    c1 = '0;
    if (cq0.size() != 0) c0 = cq0[0];
    if (cq1.size() != 0) c1 = cq1[0];
    rd[0] = c0.rd; wr[0] = c0.wr; lk[0] = c0.lk; ad[0] = c0.a; be[0] = c0.be; wd[0] = c0.d;
    rd[1] = c1.rd; wr[1] = c1.wr; lk[1] = c1.lk; ad[1] = c1.a; be[1] = c1.be; wd[1] = c1.d;
  endtask

  task automatic accept(input int p, input cmd_t c);
    exp_t e;
    glog.push_back(p);
    if (c.wr) begin
      for (int b = 0; b < 4; b++)
        if (c.be[b]) shadow[c.a][8*b +: 8] = c.d[8*b +: 8];
    end else if (c.rd) begin
      e.p   = p[0];
      e.d   = shadow[c.a];
      e.due = cyc + 1;
      eq.push_back(e);
    end
  endtask

  // One clock: check returns and record accepts at negedge, then advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rdv != 2'b00) begin
      if (eq.size() == 0) begin
        check("rdv_spurious", 32'(rdv), 32'd0);
      end else begin
        e = eq.pop_front();
        check("rdv_port", 32'(rdv), e.p ? 32'd2 : 32'd1);
        check("rdata", rdat[e.p], e.d);
        check("rdv_cycle", cyc, e.due);
      end
    end
    if (cq0.size() != 0 && !wreq[0]) accept(0, cq0.pop_front());
    if (cq1.size() != 0 && !wreq[1]) accept(1, cq1.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_cmds();
    int n = 0;
    while ((cq0.size() != 0 || cq1.size() != 0) && n < 200) begin
      present();
      step();
      n++;
    end
    if (n >= 200) begin
      check("timeout", 32'd1, 32'd0);
      cq0.delete();
      cq1.delete();
    end
    present();
    repeat (3) step();
    check("rdv_missing", 32'(eq.size()), 32'd0);
  endtask

  task automatic check_grants(input string tag, input logic [31:0] pat, input int n);
    check({tag, "_len"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < n && i < glog.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(glog[i]), 32'(pat[i]));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    present();
    eq.delete();
    glog.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(i);
    reset_n = 1'b0;
    present();
    rd[0] = 1'b1;

    // Reset state, with a request already pending on port 0
    @(negedge clk);
    check("rst_waitreq", 32'(wreq), 32'd3);
    check("rst_rdv", 32'(rdv), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_wr", 32'(mem_write), 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd0);
    check("rst_err", 32'(err_proto), 32'd0);
    rd[0] = 1'b0;
    do_reset();
    check("clken", 32'(mem_clken), 32'd1);

    // Single read of the preloaded word
    cq0.push_back(mk(1'b1, 1'b0, 1'b0, 17'h00010, 4'hF, 32'h0));
    run_cmds();
    check_grants("t1", 32'h0, 1);

    // Both ports reading every cycle without lock
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cq0.push_back(mk(1'b1, 1'b0, 1'b0, 17'(32'h100 + i), 4'hF, 32'h0));
      cq1.push_back(mk(1'b1, 1'b0, 1'b0, 17'(32'h200 + i), 4'hF, 32'h0));
    end
    run_cmds();
    check_grants("alt", 32'hAA, 8);

    // Locked writes on port 0 against reads on port 1, MAX_HOLD = 4
    do_reset();
    for (int i = 0; i < 8; i++)
      cq0.push_back(mk(1'b0, 1'b1, 1'b1, 17'(32'h300 + i), 4'hF, 32'hA0000000 + 32'(i)));
    for (int i = 0; i < 2; i++)
      cq1.push_back(mk(1'b1, 1'b0, 1'b0, 17'(32'h400 + i), 4'hF, 32'h0));
    run_cmds();
    check_grants("lock", 32'h210, 10);
    cq0.push_back(mk(1'b1, 1'b0, 1'b0, 17'h00303, 4'hF, 32'h0));
    run_cmds();

    // Partial-byte write then read back from the other port
    do_reset();
    cq1.push_back(mk(1'b0, 1'b1, 1'b0, 17'h12BFF, 4'b0011, 32'h12345678));
    run_cmds();
    cq0.push_back(mk(1'b1, 1'b0, 1'b0, 17'h12BFF, 4'hF, 32'h0));
    run_cmds();
    check_grants("be", 32'h1, 2);

    // Read and write asserted together
    do_reset();
    cq0.push_back(mk(1'b1, 1'b1, 1'b0, 17'h00500, 4'hF, 32'hCAFEF00D));
    run_cmds();
    check("err_set", 32'(err_proto), 32'd1);
    cq0.push_back(mk(1'b1, 1'b0, 1'b0, 17'h00500, 4'hF, 32'h0));
    run_cmds();
    check("err_held", 32'(err_proto), 32'd1);
    reset_n = 1'b0;
    #1;
    check("err_clr", 32'(err_proto), 32'd0);

    // Reset the cycle after an accepted read
    do_reset();
    rd[0] = 1'b1;
    ad[0] = 17'h00010;
    be[0] = 4'hF;
    @(negedge clk);
    check("t6_acc", 32'(wreq[0]), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    rd[0]   = 1'b0;
    @(negedge clk);
    check("t6_rdv_rst", 32'(rdv), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hits = 0;
    repeat (5) begin
      @(negedge clk);
      if (rdv != 2'b00) hits++;
    end
    check("t6_no_rdv", 32'(hits), 32'd0);
    @(posedge clk);
    #1;
    glog.delete();
    cq0.push_back(mk(1'b1, 1'b0, 1'b0, 17'h00010, 4'hF, 32'h0));
    cq1.push_back(mk(1'b1, 1'b0, 1'b0, 17'h00011, 4'hF, 32'h0));
    run_cmds();
    check_grants("t6_tie", 32'h2, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
